// File: rtl/debounce_pkg.sv
// Shared defaults for the multi-channel switch debouncer.
// Holds the debounce limit, channel count, reset level and width helper.
package debounce_pkg;

  localparam int   DEF_DEBOUNCE_LIMIT = 250000;
  localparam int   DEF_NUM_CH         = 4;
  localparam logic DEF_RESET_STATE    = 1'b0;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debouncer_multi_if.sv
// Switch bundle: raw levels in, debounced levels and edge pulses out.
// master drives sw and observes results; slave is the debouncer side.
interface debouncer_multi_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] sw;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              any_change;

  modport master (
    output sw,
    input  level,
    input  rise,
    input  fall,
    input  any_change
  );

  modport slave (
    input  sw,
    output level,
    output rise,
    output fall,
    output any_change
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop sync, stability counter, level, edge pulses.
// Ports: i_Clk, i_Rst_n, i_Switch (raw), o_Switch, o_Rise, o_Fall.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   c_DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter logic RESET_STATE      = DEF_RESET_STATE
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int CW = cnt_width(c_DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CMAX = CW'(c_DEBOUNCE_LIMIT - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1    <= RESET_STATE;
      sync2    <= RESET_STATE;
      o_Switch <= RESET_STATE;
      level_q  <= RESET_STATE;
      o_Rise   <= 1'b0;
      o_Fall   <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1   <= i_Switch;
      sync2   <= sync1;
      level_q <= o_Switch;
      // pulses follow the level change by one cycle
      o_Rise  <= o_Switch & ~level_q;
      o_Fall  <= ~o_Switch & level_q;
      if (sync2 == o_Switch) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        o_Switch <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: NUM_CH independent channels.
// Ports: i_Clk, i_Rst_n, i_Switch, o_Switch, o_Rise, o_Fall, o_Any_Change.
module debouncer_multi
  import debounce_pkg::*;
#(
  parameter int   NUM_CH           = DEF_NUM_CH,
  parameter int   c_DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter logic RESET_STATE      = DEF_RESET_STATE
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_channel #(
      .c_DEBOUNCE_LIMIT (c_DEBOUNCE_LIMIT),
      .RESET_STATE      (RESET_STATE)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_Switch (i_Switch[n]),
      .o_Switch (o_Switch[n]),
      .o_Rise   (o_Rise[n]),
      .o_Fall   (o_Fall[n])
    );
  end

  assign o_Any_Change = |{o_Rise, o_Fall};

endmodule

// File: tb/tb_debouncer_multi.sv
// Randomized + directed bench for debouncer_multi (2 ch, limit 4).
// Behavioural window model checked every cycle, plus literal latencies.
module tb_debouncer_multi;

  localparam int NCH = 2;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  debouncer_multi_if #(.NUM_CH(NCH)) bus ();

  debouncer_multi #(
    .NUM_CH           (NCH),
    .c_DEBOUNCE_LIMIT (LIM),
    .RESET_STATE      (1'b0)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Switch     (bus.sw),
    .o_Switch     (bus.level),
    .o_Rise       (bus.rise),
    .o_Fall       (bus.fall),
    .o_Any_Change (bus.any_change)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
  endtask

  // Model: a change is accepted when the last LIM samples (taken two
  // cycles after the raw input) all differ from the current level.
  logic [NCH-1:0] m1, m2, lvl, rise_e, fall_e, pend_r, pend_f;
  logic [LIM-1:0] win [NCH];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m1 = '0; m2 = '0; lvl = '0;
        rise_e = '0; fall_e = '0; pend_r = '0; pend_f = '0;
        for (int n = 0; n < NCH; n++) win[n] = '0;
      end else begin
        for (int n = 0; n < NCH; n++) begin
          logic s;
          s = m2[n];
          m2[n] = m1[n];
          m1[n] = bus.sw[n];
          rise_e[n] = pend_r[n];
          fall_e[n] = pend_f[n];
          pend_r[n] = 1'b0;
          pend_f[n] = 1'b0;
          win[n] = {win[n][LIM-2:0], s};
          if (win[n] == {LIM{~lvl[n]}}) begin
            lvl[n] = s;
            pend_r[n] = s;
            pend_f[n] = ~s;
          end
        end
      end
      #1;
      chk("o_Switch", 32'(bus.level), 32'(lvl));
      chk("o_Rise", 32'(bus.rise), 32'(rise_e));
      chk("o_Fall", 32'(bus.fall), 32'(fall_e));
      chk("o_Any_Change", 32'(bus.any_change), 32'(|{rise_e, fall_e}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] v);
    @(negedge clk);
    bus.sw = v;
  endtask

  task automatic wait_cyc(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int pulses;
    logic seen;
    int hold [NCH];

    bus.sw = '0;
    rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_state", 32'({bus.level, bus.rise, bus.fall, bus.any_change}), 32'd0);
    rst_n = 1'b1;

    // quiet input: nothing happens
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | bus.any_change | (|bus.level);
    end
    chk("quiet_20", 32'(seen), 32'd0);

    // single rising edge on ch0
    drive(2'b01);
    cnt = 0;
    do begin tick(); cnt++; end while (!bus.level[0] && cnt < 50);
    chk("rise_latency", 32'(cnt), 32'd6);
    tick();
    chk("rise_pulse", 32'(bus.rise), 32'b01);
    chk("rise_any", 32'(bus.any_change), 32'd1);
    tick();
    chk("rise_one_cycle", 32'(bus.rise), 32'd0);

    drive(2'b00);
    wait_cyc(12);
    chk("back_low", 32'(bus.level), 32'd0);

    // glitch train never reaches LIM consecutive samples
    seen = 1'b0;
    for (int r = 0; r < 5; r++) begin
      drive(2'b01);
      for (int i = 0; i < 3; i++) begin
        tick();
        seen = seen | bus.level[0] | bus.any_change;
      end
      drive(2'b00);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | bus.level[0] | bus.any_change;
    end
    chk("glitch_reject", 32'(seen), 32'd0);

    // both channels together
    drive(2'b11);
    cnt = 0;
    do begin tick(); cnt++; end while (bus.level == 2'b00 && cnt < 50);
    chk("both_latency", 32'(cnt), 32'd6);
    chk("both_level", 32'(bus.level), 32'b11);
    tick();
    chk("both_rise", 32'(bus.rise), 32'b11);

    // fall on ch1
    drive(2'b01);
    cnt = 0;
    do begin tick(); cnt++; end while (!bus.fall[1] && cnt < 50);
    chk("fall_latency", 32'(cnt), 32'd7);
    chk("fall_no_rise", 32'(bus.rise[1]), 32'd0);
    tick();
    chk("fall_one_cycle", 32'(bus.fall), 32'd0);

    // reset mid-count
    drive(2'b10);
    wait_cyc(12);
    chk("pre_reset_lvl", 32'(bus.level), 32'b10);
    drive(2'b11);
    for (int i = 0; i < 4; i++) tick();
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'({bus.level, bus.rise, bus.fall}), 32'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    cnt = 0;
    pulses = 0;
    do begin tick(); cnt++; end while (!bus.level[0] && cnt < 50);
    chk("post_reset_latency", 32'(cnt), 32'd6);
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(bus.rise[0]);
    end
    chk("post_reset_pulses", 32'(pulses), 32'd1);

    // random phase: bursty holds, occasional reset
    for (int n = 0; n < NCH; n++) hold[n] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      for (int n = 0; n < NCH; n++) begin
        if (hold[n] == 0) begin
          bus.sw[n] = 1'($urandom_range(0, 1));
          hold[n] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12)
                                                : $urandom_range(1, 4);
        end else begin
          hold[n]--;
        end
      end
    end
    wait_cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
